// File: rtl/coo_edge_sequencer_if.sv
// Beat bus from the edge sequencer to its consumers.
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. The master holds out_base, out_lane_en and out_last
// stable while out_valid is 1 and out_ready is 0. The slave may change
// out_ready at any time, and out_valid does not depend on out_ready.
interface coo_edge_sequencer_if #(
  parameter int COO_BW = 3,
  parameter int LANES  = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [COO_BW-1:0] out_base;
  logic [LANES-1:0]  out_lane_en;
  logic              out_last;

  modport master (
    output out_valid,
    output out_base,
    output out_lane_en,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_base,
    input  out_lane_en,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/coo_edge_sequencer.sv
// Edge-index sequencer for the COO edge list. Walks indices 0..count-1 in
// beats of LANES consecutive indices, masks the partial final beat, and can
// loop over the list until stop is seen. All outputs are registered.
module coo_edge_sequencer #(
  parameter int COO_EDGES = 6,
  parameter int LANES     = 2,
  parameter int COO_BW    = (COO_EDGES > 1) ? $clog2(COO_EDGES) : 1,
  parameter int PASS_BW   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COO_BW:0]       edge_count,
  input  logic                  mode_loop,
  input  logic                  stop,
  coo_edge_sequencer_if.master  beat,
  output logic                  busy,
  output logic                  done,
  output logic [PASS_BW-1:0]    pass_cnt,
  output logic [1:0]            dbg_state
);

  // Wide enough that base + LANES (and base + lane index) never overflows.
  localparam int SUM_BW = COO_BW + $clog2(LANES) + 2;
  localparam logic [COO_BW:0] MAX_CNT = (COO_BW + 1)'(COO_EDGES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [COO_BW-1:0]    r_base;
  logic [COO_BW:0]      r_cnt;
  logic                 r_loop;
  logic [PASS_BW-1:0]   r_pass;
  logic                 r_valid;
  logic [LANES-1:0]     r_lane_en;
  logic                 r_last;
  logic                 r_done;
  logic                 r_busy;

  logic [COO_BW-1:0]    w_base_nxt;
  logic [COO_BW:0]      w_cnt_nxt;
  logic                 w_loop_nxt;
  logic [PASS_BW-1:0]   w_pass_nxt;
  logic                 w_valid_nxt;
  logic [LANES-1:0]     w_lane_en_nxt;
  logic                 w_last_nxt;
  logic                 w_done_nxt;
  logic                 w_busy_nxt;

  logic [COO_BW:0]      w_cnt_clamp;
  logic                 w_accept;

  // Lane i is live when base + i is still inside the edge list.
  function automatic logic [LANES-1:0] f_lane_mask(
    input logic [COO_BW-1:0] base,
    input logic [COO_BW:0]   cnt
  );
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (SUM_BW'(base) + SUM_BW'(i)) < SUM_BW'(cnt);
    end
    return m;
  endfunction

  // The beat is last when it reaches or passes the end of the list.
  function automatic logic f_is_last(
    input logic [COO_BW-1:0] base,
    input logic [COO_BW:0]   cnt
  );
    return (SUM_BW'(base) + SUM_BW'(LANES)) >= SUM_BW'(cnt);
  endfunction

  assign w_cnt_clamp = (edge_count > MAX_CNT) ? MAX_CNT : edge_count;
  assign w_accept    = r_valid & beat.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_cnt_nxt   = r_cnt;
    w_loop_nxt  = r_loop;
    w_pass_nxt  = r_pass;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_nxt   = w_cnt_clamp;
          w_loop_nxt  = mode_loop;
          w_pass_nxt  = '0;
          w_base_nxt  = '0;
          w_state_nxt = (w_cnt_clamp == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        // stop only cancels looping; the pass in flight always completes.
        if (stop) begin
          w_loop_nxt = 1'b0;
        end
        if (w_accept) begin
          if (r_last) begin
            w_pass_nxt  = r_pass + PASS_BW'(1);
            w_base_nxt  = '0;
            w_state_nxt = (r_loop && !stop) ? S_RUN : S_FIN;
          end else begin
            w_base_nxt = r_base + COO_BW'(LANES);
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    w_valid_nxt   = (w_state_nxt == S_RUN);
    w_lane_en_nxt = '0;
    w_last_nxt    = 1'b0;
    if (w_valid_nxt) begin
      w_lane_en_nxt = f_lane_mask(w_base_nxt, w_cnt_nxt);
      w_last_nxt    = f_is_last(w_base_nxt, w_cnt_nxt);
    end
    w_done_nxt = (w_state_nxt == S_FIN);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base    <= '0;
      r_cnt     <= '0;
      r_loop    <= 1'b0;
      r_pass    <= '0;
      r_valid   <= 1'b0;
      r_lane_en <= '0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_base    <= w_base_nxt;
      r_cnt     <= w_cnt_nxt;
      r_loop    <= w_loop_nxt;
      r_pass    <= w_pass_nxt;
      r_valid   <= w_valid_nxt;
      r_lane_en <= w_lane_en_nxt;
      r_last    <= w_last_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign beat.out_valid   = r_valid;
  assign beat.out_base    = r_base;
  assign beat.out_lane_en = r_lane_en;
  assign beat.out_last    = r_last;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass_cnt         = r_pass;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_coo_edge_sequencer.sv
// Directed bench for coo_edge_sequencer: one instance with LANES=4 and one
// with LANES=2, both over a 6-edge list.
module tb_coo_edge_sequencer;
  localparam int COO_EDGES = 6;
  localparam int COO_BW    = 3;
  localparam int PASS_BW   = 8;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst4, start4, loop4, stop4, busy4, done4;
  logic [COO_BW:0]   cnt4;
  logic [PASS_BW-1:0] pass4;
  logic [1:0]        st4;
  logic              rst2, start2, loop2, stop2, busy2, done2;
  logic [COO_BW:0]   cnt2;
  logic [PASS_BW-1:0] pass2;
  logic [1:0]        st2;

  coo_edge_sequencer_if #(.COO_BW(COO_BW), .LANES(4)) bus4 ();
  coo_edge_sequencer_if #(.COO_BW(COO_BW), .LANES(2)) bus2 ();

  coo_edge_sequencer #(.COO_EDGES(COO_EDGES), .LANES(4), .COO_BW(COO_BW), .PASS_BW(PASS_BW)) u_dut4 (
    .clk(clk), .reset(rst4), .start(start4), .edge_count(cnt4), .mode_loop(loop4),
    .stop(stop4), .beat(bus4.master), .busy(busy4), .done(done4), .pass_cnt(pass4),
    .dbg_state(st4)
  );

  coo_edge_sequencer #(.COO_EDGES(COO_EDGES), .LANES(2), .COO_BW(COO_BW), .PASS_BW(PASS_BW)) u_dut2 (
    .clk(clk), .reset(rst2), .start(start2), .edge_count(cnt2), .mode_loop(loop2),
    .stop(stop2), .beat(bus2.master), .busy(busy2), .done(done2), .pass_cnt(pass2),
    .dbg_state(st2)
  );

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] beat2();
    return {bus2.out_last, bus2.out_lane_en, bus2.out_base};
  endfunction

  function automatic logic [7:0] beat4();
    return {bus4.out_last, bus4.out_lane_en, bus4.out_base};
  endfunction

  int  t3_base[6] = '{0, 2, 4, 0, 2, 4};
  int  t3_last[6] = '{0, 0, 1, 0, 0, 1};
  int  n_acc;
  bit  fin;
  bit  acc;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst4 = 1'b0; start4 = 1'b0; loop4 = 1'b0; stop4 = 1'b0; cnt4 = '0;
    rst2 = 1'b0; start2 = 1'b0; loop2 = 1'b0; stop2 = 1'b0; cnt2 = '0;
    bus4.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_valid4", bus4.out_valid, 0);
    chk("rst_beat4", beat4(), 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_pass4", pass4, 0);
    chk("rst_state4", st4, 0);
    chk("rst_valid2", bus2.out_valid, 0);
    chk("rst_beat2", beat2(), 0);
    rst4 = 1'b1;
    rst2 = 1'b1;
    step();

    // Single pass, LANES=4, 6 edges
    start4 = 1'b1; cnt4 = 4'd6; loop4 = 1'b0;
    step();
    start4 = 1'b0;
    chk("t1_valid0", bus4.out_valid, 1);
    chk("t1_beat0", beat4(), {1'b0, 4'b1111, 3'd0});
    chk("t1_busy", busy4, 1);
    step();
    chk("t1_beat1", beat4(), {1'b1, 4'b0011, 3'd4});
    step();
    chk("t1_valid_fin", bus4.out_valid, 0);
    chk("t1_done", done4, 1);
    chk("t1_pass", pass4, 1);
    step();
    chk("t1_done_drop", done4, 0);
    chk("t1_idle", busy4, 0);

    // Backpressure, LANES=2, 5 edges, ready pattern 1,0,0
    exp_q.push_back({1'b0, 2'b11, 3'd0});
    exp_q.push_back({1'b0, 2'b11, 3'd2});
    exp_q.push_back({1'b1, 2'b01, 3'd4});
    start2 = 1'b1; cnt2 = 4'd5; loop2 = 1'b0;
    step();
    start2 = 1'b0;
    n_acc = 0;
    fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      bus2.out_ready = (c % 3 == 0);
      acc = 1'b0;
      if (bus2.out_valid) begin
        chk("t2_beat_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("t2_beat", beat2(), exp_q[0]);
          acc = bus2.out_ready;
        end
      end
      step();
      if (acc) begin
        void'(exp_q.pop_front());
        n_acc++;
      end
      if (done2) fin = 1'b1;
    end
    bus2.out_ready = 1'b1;
    chk("t2_done_seen", fin, 1);
    chk("t2_accepts", n_acc, 3);
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_pass", pass2, 1);
    step();
    chk("t2_done_once", done2, 0);

    // Loop mode with stop in the second pass
    start2 = 1'b1; cnt2 = 4'd6; loop2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("t3_valid", bus2.out_valid, 1);
      chk("t3_base", bus2.out_base, t3_base[c]);
      chk("t3_last", bus2.out_last, t3_last[c]);
      if (c == 3) chk("t3_pass_mid", pass2, 1);
      stop2 = (c == 4);
      step();
    end
    stop2 = 1'b0;
    chk("t3_done", done2, 1);
    chk("t3_valid_fin", bus2.out_valid, 0);
    chk("t3_pass", pass2, 2);
    step();

    // Zero count, then start ignored in FIN, then clamped run with start held
    start2 = 1'b1; cnt2 = 4'd0; loop2 = 1'b0;
    step();
    chk("t4_zero_valid", bus2.out_valid, 0);
    chk("t4_zero_done", done2, 1);
    chk("t4_zero_busy", busy2, 1);
    cnt2 = 4'd9;
    step();
    chk("t4_fin_start_ignored", bus2.out_valid, 0);
    chk("t4_idle_busy", busy2, 0);
    chk("t4_idle_done", done2, 0);
    step();
    chk("t4_clamp_beat0", beat2(), {1'b0, 2'b11, 3'd0});
    cnt2 = 4'd2;
    step();
    chk("t4_clamp_beat1", beat2(), {1'b0, 2'b11, 3'd2});
    start2 = 1'b0;
    step();
    chk("t4_clamp_beat2", beat2(), {1'b1, 2'b11, 3'd4});
    step();
    chk("t4_clamp_done", done2, 1);
    chk("t4_clamp_pass", pass2, 1);
    step();

    // Reset during the second beat
    start2 = 1'b1; cnt2 = 4'd6; loop2 = 1'b0;
    step();
    start2 = 1'b0;
    chk("t5_beat0", beat2(), {1'b0, 2'b11, 3'd0});
    step();
    chk("t5_beat1", beat2(), {1'b0, 2'b11, 3'd2});
    rst2 = 1'b0;
    step();
    chk("t5_rst_valid", bus2.out_valid, 0);
    chk("t5_rst_beat", beat2(), 0);
    chk("t5_rst_busy", busy2, 0);
    chk("t5_rst_done", done2, 0);
    chk("t5_rst_state", st2, 0);
    rst2 = 1'b1;
    step();
    chk("t5_no_done", done2, 0);
    chk("t5_still_idle", busy2, 0);
    start2 = 1'b1; cnt2 = 4'd4;
    step();
    start2 = 1'b0;
    chk("t5_rerun_beat0", beat2(), {1'b0, 2'b11, 3'd0});
    step();
    chk("t5_rerun_beat1", beat2(), {1'b1, 2'b11, 3'd2});
    step();
    chk("t5_rerun_done", done2, 1);
    chk("t5_rerun_pass", pass2, 1);
    step();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
